main_mem_responder: RTL and testbench
=====================================

Name: main_mem_responder

Overview:
Backing-memory responder on the far side of the instruction/data cache refill port of the multicycle CPU.
- Accepts one request at a time from the cache (initiator) over a valid/ready handshake.
- Waits a programmable latency, then returns either a line-fill burst (reads) or a single write acknowledge beat, with response backpressure.
- Serves as the synthesizable main-memory model for CPU-level simulation and FPGA bring-up.

Parameters:
MEM_WORDS, 4096, depth of word array (power of 2)
LINE_WORDS, 4, words per read burst (power of 2, 1..16)
LAT_CYCLES, 3, wait cycles between request accept and first response beat (0..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept request
req_we  in  1  1 = word write, 0 = line read
req_addr  in  32  byte address; bits [1:0] ignored
req_wdata  in  32  write data
req_wstrb  in  4  byte enables for write
rsp_valid  out  1  response beat present
rsp_ready  in  1  initiator accepts beat
rsp_data  out  32  read data (0 for write ack)
rsp_last  out  1  final beat of response
rsp_err  out  1  error flag (see Optional Feature)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (reset low, asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_last=0, rsp_err=0, busy=0, beat counter=0, latency counter=0. Memory contents are not cleared.
- States:
  - IDLE: req_ready=1. Handshake = req_valid & req_ready. On handshake, capture we/addr/wdata/wstrb and load the latency counter with LAT_CYCLES. Go to WAIT if LAT_CYCLES>0, else RESP.
  - WAIT: counter decrements each cycle. When counter==1, go to RESP.
  - RESP: rsp_valid=1.
- req_ready=0 in all states except IDLE. Requests never overlap.
- Latency: request accepted on edge E0 → rsp_valid first high in the cycle after edge E0+LAT_CYCLES+1.
  - LAT_CYCLES=0: rsp_valid rises on the edge after accept.
- Read burst:
  - Base word index = (req_addr[31:2] & ~(LINE_WORDS-1)) mod MEM_WORDS.
  - Beats return in ascending order. Beat i = mem[(base+i) mod MEM_WORDS].
  - rsp_data is registered: loaded on entry to RESP and on each beat accept (rsp_valid & rsp_ready).
  - rsp_last=1 on beat LINE_WORDS-1. Accepting the last beat returns to IDLE; req_ready=1 the next cycle.
- Write:
  - On entry to RESP, write mem[word index] byte lanes where req_wstrb[k]=1. req_wstrb=0 writes nothing but is still acknowledged.
  - One beat: rsp_data=0, rsp_last=1. Return to IDLE on accept.
- Backpressure: while rsp_valid & !rsp_ready, rsp_data/rsp_last/rsp_err hold stable. No beat is skipped or duplicated.
- A read issued the cycle after a write to the same address returns the new data.
- Reset asserted mid-operation aborts the pending response: the read burst is truncated, and a write that already committed stays in memory. Post-reset behaviour matches power-up except memory contents.
- Inputs other than rsp_ready are ignored outside IDLE.

Optional Feature:
MAIN_MEM_BOUNDS_CHK_EN
- Defined: a request with req_addr[31:2] >= MEM_WORDS is flagged.
  - Read: a full LINE_WORDS burst with rsp_data=0 and rsp_err=1 on every beat.
  - Write: no memory update; ack beat carries rsp_err=1.
- Undefined: the address is reduced modulo MEM_WORDS, and rsp_err is tied to 0.

Decomposition:
- Package main_mem_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - DEFAULT_LINE_WORDS, DEFAULT_LAT_CYCLES
  - word/byte width constants
  - the function computing the line-aligned base index
- One sub-module, main_mem_array: MEM_WORDS x 32 storage, one write port with 4-bit byte enable, one asynchronous read port. The FSM registers the read output into rsp_data.

Test Plan:
- Preload mem[0x10..0x13]=0xA0..0xA3, LAT_CYCLES=3, read req_addr=0x48 → beats 0xA0,0xA1,0xA2,0xA3. rsp_last only on 4th beat. First rsp_valid 4 cycles after accept edge.
- Write 0xDEADBEEF to 0x100 with wstrb=4'b0101 over prior 0x11223344 → one ack beat (rsp_last=1, rsp_data=0). Following read of line 0x100 returns 0x11AD33EF at beat 0.
- Read burst with rsp_ready toggling 1,0,0,1,0,1 → rsp_data stable during stalls, all 4 beats delivered exactly once, req_ready low until final accept.
- LAT_CYCLES=0, back-to-back reads at 0x0 then 0x10 with req_valid held high → second accept in the first cycle after the first burst's last beat; busy high throughout the bursts.
- Reset pulsed low during beat 2 of a read → next cycle rsp_valid=0, req_ready=1, busy=0. A new read returns correct data from beat 0.
- With MAIN_MEM_BOUNDS_CHK_EN, MEM_WORDS=4096, read 0x4000 → 4 beats, rsp_err=1, data 0. Without the macro, the same read returns the mem[0..3] contents.

Source files
------------

// File: rtl/main_mem_pkg.sv
// Shared types and constants for the main-memory responder.
package main_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int STRB_W = WORD_W / BYTE_W;

    localparam int DEFAULT_MEM_WORDS  = 4096;
    localparam int DEFAULT_LINE_WORDS = 4;
    localparam int DEFAULT_LAT_CYCLES = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Word index of the first word of the line containing word_addr.
    function automatic logic [29:0] line_base(input logic [29:0] word_addr,
                                              input int          line_words);
        return word_addr & ~30'(line_words - 1);
    endfunction

endpackage

// File: rtl/main_mem_if.sv
// Request/response channel between a cache refill port and the memory responder.
interface main_mem_if;
    import main_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_data;
    logic              rsp_last;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
    );

endinterface

// File: rtl/main_mem_array.sv
// Word storage with one byte-enabled write port and one asynchronous read port.
module main_mem_array
    import main_mem_pkg::*;
#(
    parameter  int MEM_WORDS = DEFAULT_MEM_WORDS,
    localparam int AW        = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic [AW-1:0]     rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [MEM_WORDS];

    // NOTE: the array has no reset; contents must survive a reset pulse and a
    // reset loop over thousands of words would also defeat RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (wr_strb[k]) begin
                    mem[wr_idx][k*BYTE_W +: BYTE_W] <= wr_data[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/main_mem_responder.sv
// Backing-memory responder for the cache refill port: latency, line bursts, write acks.
// Define MAIN_MEM_BOUNDS_CHK_EN to flag out-of-range word addresses with rsp_err.
module main_mem_responder
    import main_mem_pkg::*;
#(
    parameter int MEM_WORDS  = DEFAULT_MEM_WORDS,
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
    parameter int LAT_CYCLES = DEFAULT_LAT_CYCLES
) (
    input  logic      clk,
    input  logic      reset,
    main_mem_if.slave bus,
    output logic      busy
);

    localparam int            AW        = $clog2(MEM_WORDS);
    localparam int            BW        = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
    localparam logic [7:0]    LAT_INIT  = 8'(LAT_CYCLES);

    state_e            state_q, state_d;
    logic [7:0]        lat_cnt_q, lat_cnt_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              we_q, we_d;
    logic [29:0]       waddr_q, waddr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_last_q, rsp_last_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;

    logic              idle;
    logic              cur_we;
    logic [29:0]       cur_waddr;
    logic [WORD_W-1:0] cur_wdata;
    logic [STRB_W-1:0] cur_wstrb;
    logic [29:0]       cur_base;
    logic              cur_oob;
    logic              oob_eff;
    logic              enter_resp;
    logic              mem_wr;
    logic [AW-1:0]     rd_idx;
    logic [WORD_W-1:0] rd_data;
    logic              unused_bits;

    // The live bus feeds the datapath in IDLE so a zero-latency request can
    // commit its write and load beat 0 on its own accept edge.
    assign idle      = (state_q == IDLE);
    assign cur_we    = idle ? bus.req_we          : we_q;
    assign cur_waddr = idle ? bus.req_addr[31:2]  : waddr_q;
    assign cur_wdata = idle ? bus.req_wdata       : wdata_q;
    assign cur_wstrb = idle ? bus.req_wstrb       : wstrb_q;
    assign cur_base  = line_base(cur_waddr, LINE_WORDS);
    assign cur_oob   = {2'b00, cur_waddr} >= 32'(MEM_WORDS);

`ifdef MAIN_MEM_BOUNDS_CHK_EN
    assign oob_eff = cur_oob;
`else
    assign oob_eff = 1'b0;
`endif

    assign rd_idx = (state_q == RESP) ? cur_base[AW-1:0] + AW'(beat_q) + AW'(1)
                                      : cur_base[AW-1:0];

    assign unused_bits = ^{bus.req_addr[1:0], cur_base[29:AW], cur_oob};

    main_mem_array #(.MEM_WORDS(MEM_WORDS)) u_array (
        .clk     (clk),
        .wr_en   (mem_wr),
        .wr_idx  (cur_waddr[AW-1:0]),
        .wr_data (cur_wdata),
        .wr_strb (cur_wstrb),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_comb begin
        // NOTE: every _d starts as its _q, so no path through this block infers a latch.
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        beat_d      = beat_q;
        we_d        = we_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;
        busy_d      = busy_q;
        enter_resp  = 1'b0;
        mem_wr      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    we_d        = bus.req_we;
                    waddr_d     = bus.req_addr[31:2];
                    wdata_d     = bus.req_wdata;
                    wstrb_d     = bus.req_wstrb;
                    lat_cnt_d   = LAT_INIT;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (LAT_CYCLES == 0) enter_resp = 1'b1;
                    else                 state_d    = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q == 8'd1) enter_resp = 1'b1;
                else                   lat_cnt_d  = lat_cnt_q - 8'd1;
            end
            RESP: begin
                // First RESP cycle presents nothing; beat 0 is already loaded.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (bus.rsp_ready) begin
                    if (rsp_last_q) begin
                        state_d     = IDLE;
                        beat_d      = '0;
                        rsp_valid_d = 1'b0;
                        rsp_data_d  = '0;
                        rsp_last_d  = 1'b0;
                        rsp_err_d   = 1'b0;
                        req_ready_d = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        beat_d     = beat_q + BW'(1);
                        rsp_data_d = oob_eff ? '0 : rd_data;
                        rsp_last_d = (beat_q + BW'(1)) == LAST_BEAT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            state_d    = RESP;
            lat_cnt_d  = '0;
            beat_d     = '0;
            mem_wr     = cur_we && !oob_eff;
            rsp_data_d = (cur_we || oob_eff) ? '0 : rd_data;
            rsp_last_d = cur_we || (LINE_WORDS == 1);
            rsp_err_d  = oob_eff;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            beat_q      <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            beat_q      <= beat_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: one LAT=3 and one LAT=0 instance behind a shared driver.
module tb_main_mem_responder;

`ifdef MAIN_MEM_BOUNDS_CHK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic sel;

    logic        d_req_valid;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_wstrb;
    logic        d_rsp_ready;

    logic        busy_a, busy_b;
    logic        o_req_ready, o_rsp_valid, o_rsp_last, o_rsp_err, o_busy;
    logic [31:0] o_rsp_data;

    int n_checks = 0;
    int n_pass   = 0;

    main_mem_if bus_a ();
    main_mem_if bus_b ();

    assign bus_a.req_valid = d_req_valid & ~sel;
    assign bus_a.req_we    = d_req_we;
    assign bus_a.req_addr  = d_req_addr;
    assign bus_a.req_wdata = d_req_wdata;
    assign bus_a.req_wstrb = d_req_wstrb;
    assign bus_a.rsp_ready = d_rsp_ready & ~sel;
    assign bus_b.req_valid = d_req_valid & sel;
    assign bus_b.req_we    = d_req_we;
    assign bus_b.req_addr  = d_req_addr;
    assign bus_b.req_wdata = d_req_wdata;
    assign bus_b.req_wstrb = d_req_wstrb;
    assign bus_b.rsp_ready = d_rsp_ready & sel;

    assign o_req_ready = sel ? bus_b.req_ready : bus_a.req_ready;
    assign o_rsp_valid = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    assign o_rsp_data  = sel ? bus_b.rsp_data  : bus_a.rsp_data;
    assign o_rsp_last  = sel ? bus_b.rsp_last  : bus_a.rsp_last;
    assign o_rsp_err   = sel ? bus_b.rsp_err   : bus_a.rsp_err;
    assign o_busy      = sel ? busy_b          : busy_a;

    main_mem_responder #(.MEM_WORDS(4096), .LINE_WORDS(4), .LAT_CYCLES(3)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_a),
        .busy  (busy_a)
    );

    main_mem_responder #(.MEM_WORDS(4096), .LINE_WORDS(4), .LAT_CYCLES(0)) dut_lat0 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_b),
        .busy  (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        int g = 0;
        d_req_valid = 1'b1;
        d_req_we    = we;
        d_req_addr  = addr;
        d_req_wdata = wdata;
        d_req_wstrb = strb;
        while (!o_req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check({tag, ".req_ready"}, o_req_ready, 1);
        @(negedge clk);
        d_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (!o_rsp_valid && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int exp_lat, input logic exp_err);
        int lat;
        issue(tag, 1'b1, addr, data, strb);
        wait_rsp(lat);
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".data"}, o_rsp_data, 32'h0);
        check({tag, ".last"}, o_rsp_last, 1);
        check({tag, ".err"}, o_rsp_err, exp_err);
        d_rsp_ready = 1'b1;
        @(negedge clk);
        d_rsp_ready = 1'b0;
        check({tag, ".done_valid"}, o_rsp_valid, 0);
        check({tag, ".done_ready"}, o_req_ready, 1);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [3:0][31:0] exp, input logic [3:0] dmask,
                           input logic exp_err, input logic [7:0] rdy_pat, input int exp_lat);
        int lat;
        int beat = 0;
        int cyc  = 0;
        issue(tag, 1'b0, addr, 32'h0, 4'h0);
        wait_rsp(lat);
        check({tag, ".lat"}, lat, exp_lat);
        while (beat < 4 && cyc < 40) begin
            check({tag, ".valid"}, o_rsp_valid, 1);
            if (dmask[beat]) check({tag, ".data"}, o_rsp_data, exp[beat]);
            check({tag, ".last"}, o_rsp_last, 32'(beat == 3));
            check({tag, ".err"}, o_rsp_err, exp_err);
            check({tag, ".ready_low"}, o_req_ready, 0);
            d_rsp_ready = (cyc < 8) ? rdy_pat[cyc] : 1'b1;
            @(negedge clk);
            if (d_rsp_ready) beat++;
            cyc++;
        end
        d_rsp_ready = 1'b0;
        check({tag, ".beats"}, beat, 4);
        check({tag, ".end_ready"}, o_req_ready, 1);
        check({tag, ".end_valid"}, o_rsp_valid, 0);
        check({tag, ".end_busy"}, o_busy, 0);
    endtask

    logic [31:0] b_data [16];
    logic        b_last [16];
    int          n_beats, n_acc, k_last, k_acc2, busy_bad;

    initial begin
        rst_n       = 1'b0;
        sel         = 1'b0;
        d_req_valid = 1'b0;
        d_req_we    = 1'b0;
        d_req_addr  = 32'h0;
        d_req_wdata = 32'h0;
        d_req_wstrb = 4'h0;
        d_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state on both instances.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst.req_ready", o_req_ready, 1);
            check("rst.rsp_valid", o_rsp_valid, 0);
            check("rst.rsp_data", o_rsp_data, 32'h0);
            check("rst.rsp_last", o_rsp_last, 0);
            check("rst.rsp_err", o_rsp_err, 0);
            check("rst.busy", o_busy, 0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload words 0..3 and 0x10..0x13 of the LAT=3 instance.
        for (int i = 0; i < 4; i++) do_write("pre_lo", 32'(i * 4), 32'hC0 + 32'(i), 4'hF, 4, 1'b0);
        for (int i = 0; i < 4; i++) do_write("pre_hi", 32'h40 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF, 4, 1'b0);

        // Line read from a mid-line address, latency 4.
        do_read("rd48", 32'h48, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'hF, 1'b0, 8'hFF, 4);

        // Byte-lane write, then read in the very next cycle.
        do_write("wr_full", 32'h100, 32'h11223344, 4'hF, 4, 1'b0);
        do_write("wr_strb", 32'h100, 32'hDEADBEEF, 4'b0101, 4, 1'b0);
        do_read("rd100", 32'h100, {32'h0, 32'h0, 32'h0, 32'h11AD33EF}, 4'b0001, 1'b0, 8'hFF, 4);

        // Zero strobe is acknowledged but writes nothing.
        do_write("wr_nostrb", 32'h100, 32'h00000000, 4'h0, 4, 1'b0);
        do_read("rd100b", 32'h100, {32'h0, 32'h0, 32'h0, 32'h11AD33EF}, 4'b0001, 1'b0, 8'hFF, 4);

        // Backpressure 1,0,0,1,0,1 then continuous.
        do_read("bp", 32'h40, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'hF, 1'b0, 8'hE9, 4);

        // Reset during beat 2.
        begin
            int lat;
            issue("rst_rd", 1'b0, 32'h40, 32'h0, 4'h0);
            wait_rsp(lat);
            d_rsp_ready = 1'b1;
            repeat (2) @(negedge clk);
            check("rst_rd.beat2", o_rsp_data, 32'hA2);
            d_rsp_ready = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            check("mid_rst.rsp_valid", o_rsp_valid, 0);
            check("mid_rst.req_ready", o_req_ready, 1);
            check("mid_rst.busy", o_busy, 0);
            check("mid_rst.rsp_last", o_rsp_last, 0);
            rst_n = 1'b1;
            @(negedge clk);
        end
        do_read("post_rst", 32'h40, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'hF, 1'b0, 8'hFF, 4);

        // Word index 0x1000 is past the end of a 4096-word array.
        do_read("oob_rd", 32'h4000,
                BCHK ? {32'h0, 32'h0, 32'h0, 32'h0} : {32'hC3, 32'hC2, 32'hC1, 32'hC0},
                4'hF, BCHK, 8'hFF, 4);
        do_write("oob_wr", 32'h4004, 32'h5555AAAA, 4'hF, 4, BCHK);
        do_read("rd0", 32'h0,
                {32'hC3, 32'hC2, (BCHK ? 32'hC1 : 32'h5555AAAA), 32'hC0},
                4'hF, 1'b0, 8'hFF, 4);

        // LAT=0 instance: preload, then back-to-back reads with req_valid held.
        sel = 1'b1;
        for (int i = 0; i < 8; i++) do_write("b_pre", 32'(i * 4), 32'hB0 + 32'(i), 4'hF, 1, 1'b0);
        d_req_valid = 1'b1;
        d_req_we    = 1'b0;
        d_req_addr  = 32'h0;
        d_rsp_ready = 1'b1;
        n_beats = 0; n_acc = 0; k_last = -1; k_acc2 = -1; busy_bad = 0;
        for (int k = 0; k < 40 && (n_beats < 8 || n_acc < 2); k++) begin
            if (o_req_ready && d_req_valid) begin
                n_acc++;
                if (n_acc == 2) k_acc2 = k;
            end
            if (o_rsp_valid && n_beats < 16) begin
                b_data[n_beats] = o_rsp_data;
                b_last[n_beats] = o_rsp_last;
                if (n_beats == 3) k_last = k;
                n_beats++;
            end
            if (!o_req_ready && !o_busy) busy_bad++;
            @(negedge clk);
            if (n_acc == 1) d_req_addr  = 32'h10;
            if (n_acc >= 2) d_req_valid = 1'b0;
        end
        d_rsp_ready = 1'b0;
        d_req_valid = 1'b0;
        check("b2b.accepts", n_acc, 2);
        check("b2b.beats", n_beats, 8);
        check("b2b.gap", k_acc2 - k_last, 1);
        check("b2b.busy", busy_bad, 0);
        for (int i = 0; i < 8 && i < n_beats; i++) begin
            check("b2b.data", b_data[i], 32'hB0 + 32'(i));
            check("b2b.last", b_last[i], 32'(i % 4 == 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
